// File: rtl/iq_txd_serializer_pkg.sv
// Shared widths and the per-boundary serializer decision for iq_txd_serializer.
package iq_txd_serializer_pkg;

   localparam int SYM_W         = 2;
   localparam int WORD_W        = 32;
   localparam int SYMS_PER_WORD = WORD_W / SYM_W;
   localparam int SYM_CNT_W     = $clog2(SYMS_PER_WORD);

   typedef logic [WORD_W-1:0]    word_t;
   typedef logic [SYM_W-1:0]     sym_t;
   typedef logic [SYM_CNT_W-1:0] sym_cnt_t;

   // What the shifter does at a symbol boundary.
   typedef enum logic [1:0] {
      SER_IDLE  = 2'd0,
      SER_SHIFT = 2'd1,
      SER_LOAD  = 2'd2
   } ser_action_e;

   // Finish the word in flight first, then pull a fresh one, else idle.
   function automatic ser_action_e ser_action(input sym_cnt_t sym_left, input logic empty);
      if (sym_left != '0) return SER_SHIFT;
      else if (!empty)    return SER_LOAD;
      else                return SER_IDLE;
   endfunction

endpackage

// File: rtl/iq_txd_serializer_sync_fifo.sv
// Synchronous FIFO with count-based full/empty and first-word fall-through read data.
module iq_txd_serializer_sync_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_wr;
   logic          do_rd;

   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   // Storage array: written on accepted pushes only.
   // NOTE: the memory has no reset; stale entries are unreachable because pointers and count are reset, and leaving it out keeps it mappable to RAM.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/iq_txd_serializer.sv
// AXI4-Stream slave feeding a 2-bit I/Q serializer with a forwarded symbol clock.
module iq_txd_serializer
   import iq_txd_serializer_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int CLK_DIV = 6
) (
   input  logic              s_aclk,
   input  logic              s_aresetn,
   input  logic [WORD_W-1:0] S_AXIS_tdata,
   input  logic              S_AXIS_tvalid,
   input  logic              S_AXIS_tlast,
   output logic              S_AXIS_tready,
   output logic              clk32,
   output logic [SYM_W-1:0]  iq_txd
);

   localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0] div_cnt;
   logic          boundary;
   logic          half_point;
   word_t         shreg;
   sym_cnt_t      sym_left;
   word_t         fifo_rd;
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop;
   ser_action_e   action;
   logic          unused_tlast;

   // Frames are sent back-to-back, so tlast carries no information downstream.
   assign unused_tlast = S_AXIS_tlast;

   assign boundary      = (div_cnt == DW'(CLK_DIV - 1));
   assign half_point    = (div_cnt == DW'(CLK_DIV / 2 - 1));
   assign action        = ser_action(sym_left, fifo_empty);
   assign pop           = boundary && (action == SER_LOAD);
   assign S_AXIS_tready = s_aresetn && !fifo_full;

   iq_txd_serializer_sync_fifo #(
      .DEPTH (DEPTH),
      .W     (WORD_W)
   ) u_fifo (
      .clk     (s_aclk),
      .rst_n   (s_aresetn),
      .wr_en   (S_AXIS_tvalid),
      .wr_data (S_AXIS_tdata),
      .rd_en   (pop),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Free-running divider producing a 50% duty symbol clock that falls on each boundary.
   always_ff @(posedge s_aclk or negedge s_aresetn) begin
      if (!s_aresetn) begin
         div_cnt <= '0;
         clk32   <= 1'b0;
      end else begin
         div_cnt <= boundary ? '0 : div_cnt + 1'b1;
         if (half_point)    clk32 <= 1'b1;
         else if (boundary) clk32 <= 1'b0;
      end
   end

   // Shifter: at each boundary emit the next MSB pair, reload from the FIFO, or idle at 00.
   always_ff @(posedge s_aclk or negedge s_aresetn) begin
      if (!s_aresetn) begin
         shreg    <= '0;
         sym_left <= '0;
         iq_txd   <= '0;
      end else if (boundary) begin
         unique case (action)
            SER_SHIFT: begin
               iq_txd   <= shreg[WORD_W-1 -: SYM_W];
               shreg    <= shreg << SYM_W;
               sym_left <= sym_left - 1'b1;
            end
            SER_LOAD: begin
               iq_txd   <= fifo_rd[WORD_W-1 -: SYM_W];
               shreg    <= fifo_rd << SYM_W;
               sym_left <= sym_cnt_t'(SYMS_PER_WORD - 1);
            end
            default: iq_txd <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_iq_txd_serializer.sv
// Directed self-checking bench for iq_txd_serializer (DEPTH=16, CLK_DIV=6).
module tb_iq_txd_serializer;
   import iq_txd_serializer_pkg::*;

   localparam int DEPTH   = 16;
   localparam int CLK_DIV = 6;
   localparam int BOUND   = 2 * CLK_DIV + 2;

   logic        s_aclk = 1'b0;
   logic        s_aresetn;
   logic [31:0] S_AXIS_tdata;
   logic        S_AXIS_tvalid;
   logic        S_AXIS_tlast;
   logic        S_AXIS_tready;
   logic        clk32;
   logic [1:0]  iq_txd;

   int checks   = 0;
   int failures = 0;

   iq_txd_serializer #(.DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
      .s_aclk        (s_aclk),
      .s_aresetn     (s_aresetn),
      .S_AXIS_tdata  (S_AXIS_tdata),
      .S_AXIS_tvalid (S_AXIS_tvalid),
      .S_AXIS_tlast  (S_AXIS_tlast),
      .S_AXIS_tready (S_AXIS_tready),
      .clk32         (clk32),
      .iq_txd        (iq_txd)
   );

   always #5 s_aclk = ~s_aclk;

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge s_aclk);
      #1;
   endtask

   function automatic sym_t sym_of(input word_t w, input int k);
      word_t t;
      t = w << (2 * k);
      return t[31:30];
   endfunction

   task automatic push(input word_t d, input logic last);
      S_AXIS_tvalid = 1'b1;
      S_AXIS_tdata  = d;
      S_AXIS_tlast  = last;
      tick();
      S_AXIS_tvalid = 1'b0;
      S_AXIS_tlast  = 1'b0;
   endtask

   // Advance to the next clk32 falling edge (symbol boundary); iq_txd must hold until then.
   task automatic wait_boundary(output int t);
      logic prev;
      sym_t start;
      bit   done;
      prev = clk32;
      start = iq_txd;
      done = 1'b0;
      t = 0;
      while (!done) begin
         tick();
         t++;
         if (prev === 1'b1 && clk32 === 1'b0) begin
            done = 1'b1;
         end else begin
            check("hold", iq_txd, start);
            prev = clk32;
            if (t >= BOUND) begin
               checks++;
               failures++;
               $error("FAIL boundary_timeout observed=%0d cycles expected=boundary", t);
               done = 1'b1;
            end
         end
      end
   endtask

   task automatic check_syms(input word_t w, input int k0, input bit time_first, output int t_first);
      int t;
      t_first = 0;
      for (int k = k0; k < 16; k++) begin
         wait_boundary(t);
         if (k == k0) t_first = t;
         check($sformatf("sym_%08h_%0d", w, k), iq_txd, sym_of(w, k));
         if (k > k0 || time_first) check("sym_period", t, CLK_DIV);
      end
   endtask

   task automatic check_idle(input int n);
      int t;
      for (int i = 0; i < n; i++) begin
         wait_boundary(t);
         check("idle_sym", iq_txd, 2'b00);
         check("idle_period", t, CLK_DIV);
      end
   endtask

   initial begin
      int    t;
      word_t burst [12];
      word_t fill  [16];
      logic  clk_exp [12];
      word_t w0;

      clk_exp = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};

      s_aresetn     = 1'b0;
      S_AXIS_tdata  = '0;
      S_AXIS_tvalid = 1'b0;
      S_AXIS_tlast  = 1'b0;

      // Reset state and divider waveform
      repeat (3) tick();
      #2 s_aresetn = 1'b1;
      #1;
      check("rst_clk32", clk32, 1'b0);
      check("rst_iq", iq_txd, 2'b00);
      check("rst_tready", S_AXIS_tready, 1'b1);
      for (int i = 0; i < 12; i++) begin
         tick();
         check($sformatf("clk32_edge%0d", i + 1), clk32, clk_exp[i]);
      end

      // Single word, latency from an idle shifter, then idle
      check("tready_single", S_AXIS_tready, 1'b1);
      push(32'h5555_5555, 1'b0);
      check_syms(32'h5555_5555, 0, 1'b0, t);
      check("latency", t, CLK_DIV - 1);
      check_idle(2);

      // Back-to-back words with no gap symbol
      push(32'h0000_FFFF, 1'b0);
      push(32'hFFFF_0000, 1'b1);
      check_syms(32'h0000_FFFF, 0, 1'b0, t);
      check_syms(32'hFFFF_0000, 0, 1'b1, t);
      check_idle(1);

      // Burst of 12 one-clock writes
      for (int i = 0; i < 12; i++) begin
         case (i % 3)
            0:       burst[i] = 32'h5555_5555;
            1:       burst[i] = 32'h0000_FFFF;
            default: burst[i] = 32'hFFFF_0000;
         endcase
      end
      burst[9] = 32'h5555_7557;
      for (int i = 0; i < 12; i++) begin
         check($sformatf("tready_burst%0d", i), S_AXIS_tready, 1'b1);
         push(burst[i], (i == 11));
      end
      // Symbols 0 and 1 of the first word went out during the burst; the last edge was symbol 1.
      check("burst_sym1", iq_txd, sym_of(burst[0], 1));
      check_syms(burst[0], 2, 1'b1, t);
      for (int i = 1; i < 12; i++) check_syms(burst[i], 0, 1'b1, t);
      check_idle(1);

      // Fill to DEPTH while the shifter is busy
      w0 = 32'hA5A5_C3C3;
      push(w0, 1'b0);
      wait_boundary(t);
      check("fill_w0_sym0", iq_txd, sym_of(w0, 0));
      for (int i = 0; i < DEPTH; i++) begin
         fill[i] = 32'h1234_5678 ^ (i * 32'h1111_1111);
         check($sformatf("tready_fill%0d", i), S_AXIS_tready, 1'b1);
         push(fill[i], 1'b0);
      end
      check("tready_full", S_AXIS_tready, 1'b0);
      S_AXIS_tvalid = 1'b1;
      S_AXIS_tdata  = 32'hDEAD_BEEF;
      tick();
      check("tready_full_held", S_AXIS_tready, 1'b0);
      S_AXIS_tvalid = 1'b0;
      check_syms(w0, 3, 1'b0, t);
      wait_boundary(t);
      check("fill_f0_sym0", iq_txd, sym_of(fill[0], 0));
      check("fill_f0_period", t, CLK_DIV);
      check("tready_after_pop", S_AXIS_tready, 1'b1);
      check_syms(fill[0], 1, 1'b1, t);
      for (int i = 1; i < DEPTH; i++) check_syms(fill[i], 0, 1'b1, t);
      check_idle(2);

      // Reset mid-word with words still queued
      push(32'hFFFF_FFFF, 1'b0);
      push(32'hFFFF_FFFF, 1'b0);
      push(32'hFFFF_FFFF, 1'b0);
      wait_boundary(t);
      wait_boundary(t);
      repeat (3) tick();
      check("pre_rst_clk32", clk32, 1'b1);
      check("pre_rst_iq", iq_txd, 2'b11);
      #2 s_aresetn = 1'b0;
      #1;
      check("mid_rst_iq", iq_txd, 2'b00);
      check("mid_rst_clk32", clk32, 1'b0);
      repeat (2) tick();
      #3 s_aresetn = 1'b1;
      #1;
      check("post_rst_tready", S_AXIS_tready, 1'b1);
      check_idle(17);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
